// File: rtl/fx2_emu_pkg.sv
// Shared definitions for the FX2 slave-FIFO responder: endpoint addresses,
// flag bit positions, the reset value of the flag bus and the FIFO entry layout.
// Latency: n/a (definitions only). Backpressure: n/a.
package fx2_emu_pkg;

    // Endpoint select codes on fx2_fifo_addr
    localparam logic [1:0] EP2_ADDR = 2'b00;
    localparam logic [1:0] EP6_ADDR = 2'b10;

    // Bit positions inside fx2_flags
    localparam int FLAG_EP2_NE  = 0;
    localparam int FLAG_EP6_NF  = 1;
    localparam int FLAG_EP6_NAF = 2;

    // EP2 empty, EP6 not full, EP6 not almost full
    localparam logic [2:0] FLAGS_RST = 3'b110;

    // One FIFO slot: data word plus end-of-packet marker
    typedef struct packed {
        logic        last;
        logic [15:0] dat;
    } fifo_entry_t;

endpackage

// File: rtl/fx2_emu_fifo.sv
// Purpose: synchronous first-word-fall-through FIFO of {last, data} entries with a
//          separate commit pointer; only committed entries are visible to the reader.
// Latency: a pushed+committed word is visible at the head one cycle after the push edge.
// Backpressure: push ignored when full (write pointer vs read pointer), pop ignored when
//          nothing is committed.
// Ports: clk_i/rst_i (async active-high), push_i/push_dat_i, commit_i, pop_i,
//        head_o (head entry, valid when !empty_o), empty_o, full_o, count_o (written words).
module fx2_emu_fifo
    import fx2_emu_pkg::*;
#(
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                push_i,
    input  logic [15:0]         push_dat_i,
    input  logic                commit_i,
    input  logic                pop_i,
    output fifo_entry_t         head_o,
    output logic                empty_o,
    output logic                full_o,
    output logic [DEPTH_LOG2:0] count_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   PTR_ZERO  = '0;
    localparam logic [DEPTH_LOG2-1:0] ADDR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic [DEPTH_LOG2:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]   cm_ptr_q, cm_ptr_d;
    logic [DEPTH_LOG2:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2-1:0] wr_addr, wr_addr_prev, rd_addr;
    logic                  push_ok, pop_ok;

    logic [15:0]           mem_q [DEPTH];
    logic [DEPTH-1:0]      last_q;

    assign wr_addr      = wr_ptr_q[DEPTH_LOG2-1:0];
    assign rd_addr      = rd_ptr_q[DEPTH_LOG2-1:0];
    assign wr_addr_prev = wr_addr - ADDR_ONE;

    // Full counts uncommitted words too; empty only looks at committed ones
    assign full_o  = (wr_addr == rd_addr) && (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]);
    assign empty_o = (rd_ptr_q == cm_ptr_q);
    assign count_o = wr_ptr_q - rd_ptr_q;

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    assign wr_ptr_d = wr_ptr_q + {PTR_ZERO[DEPTH_LOG2:1], push_ok};
    assign rd_ptr_d = rd_ptr_q + {PTR_ZERO[DEPTH_LOG2:1], pop_ok};
    // A same-cycle push is included in the commit
    assign cm_ptr_d = commit_i ? wr_ptr_d : cm_ptr_q;

    assign head_o.dat  = mem_q[rd_addr];
    assign head_o.last = last_q[rd_addr];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            cm_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            cm_ptr_q <= cm_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: pointers define which slots are meaningful.
    // A commit without a push re-tags the most recent uncommitted word as last.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_addr]  <= push_dat_i;
            last_q[wr_addr] <= commit_i;
        end else if (commit_i && (wr_ptr_q != cm_ptr_q)) begin
            last_q[wr_addr_prev] <= 1'b1;
        end
    end

endmodule

// File: rtl/fx2_slave_fifo_emu.sv
// Purpose: FX2 side of the slave-FIFO bus: EP2 (host->master, SLRD) and EP6
//          (master->host, SLWR/PKTEND with packet commit) plus host valid/ready streams.
// Latency: FD output is FWFT from EP2 storage; fx2_flags lag the causing edge by one ifclk;
//          EP6 words reach in_valid one cycle after the committing edge.
// Backpressure: out_ready = !EP2 full; in_valid/in_ready pops committed EP6 words;
//          strobes on empty/full are dropped and latch err_underflow/err_overflow.
// Ports: ifclk/reset, fx2_* slave-FIFO bus, out_* host->EP2 stream, in_* EP6->host stream,
//        in_zlp pulse, sticky error flags.
// Build option: define FX2_EMU_AUTOCOMMIT_EN to auto-commit EP6 every PKT_WORDS words;
//          otherwise only PKTEND commits.
module fx2_slave_fifo_emu
    import fx2_emu_pkg::*;
#(
    parameter int DEPTH_LOG2   = 9,
    parameter int PKT_WORDS    = 256,
    parameter int AFULL_MARGIN = 4
) (
    input  logic        ifclk,
    input  logic        reset,
    input  logic        fx2_sloe_b,
    input  logic        fx2_slrd_b,
    input  logic        fx2_slwr_b,
    input  logic        fx2_pktend_b,
    input  logic [1:0]  fx2_fifo_addr,
    input  logic [15:0] fx2_fd_in,
    output logic [15:0] fx2_fd_out,
    output logic        fx2_fd_oe,
    output logic [2:0]  fx2_flags,
    input  logic [15:0] out_data,
    input  logic        out_valid,
    output logic        out_ready,
    output logic [15:0] in_data,
    output logic        in_valid,
    output logic        in_last,
    input  logic        in_ready,
    output logic        in_zlp,
    output logic        err_underflow,
    output logic        err_overflow
);

`ifdef FX2_EMU_AUTOCOMMIT_EN
    localparam logic AUTO_EN = 1'b1;
`else
    localparam logic AUTO_EN = 1'b0;
`endif

    localparam logic [DEPTH_LOG2:0] CNT_ZERO   = '0;
    localparam logic [DEPTH_LOG2:0] FIFO_WORDS = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] PKT_CNT    = (DEPTH_LOG2+1)'(PKT_WORDS);
    localparam logic [DEPTH_LOG2:0] AFULL_CNT  = (DEPTH_LOG2+1)'(AFULL_MARGIN);

    logic                ep2_sel, ep6_sel;
    logic                ep2_rd_req, ep2_pop, ep2_push;
    logic                ep2_empty, ep2_full;
    logic [DEPTH_LOG2:0] ep2_count;
    fifo_entry_t         ep2_head;
    logic                ep2_last_unused;

    logic                ep6_wr_req, ep6_push, ep6_pktend, ep6_auto, ep6_commit, ep6_pop;
    logic                ep6_empty, ep6_full;
    logic [DEPTH_LOG2:0] ep6_count, ep6_free;
    fifo_entry_t         ep6_head;

    logic [DEPTH_LOG2:0] pend_cnt_q, pend_cnt_d, pend_nxt;
    logic [2:0]          flags_q, flags_d;
    logic                zlp_q, zlp_d;
    logic                err_udf_q, err_udf_d;
    logic                err_ovf_q, err_ovf_d;

    assign ep2_sel = (fx2_fifo_addr == EP2_ADDR);
    assign ep6_sel = (fx2_fifo_addr == EP6_ADDR);

    // ---------------- EP2: host -> master ----------------
    assign fx2_fd_oe  = !fx2_sloe_b && ep2_sel;
    assign ep2_rd_req = !fx2_slrd_b && ep2_sel;
    assign ep2_pop    = ep2_rd_req && !ep2_empty;
    assign ep2_push   = out_valid && !ep2_full;
    assign out_ready  = !ep2_full;

    fx2_emu_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_ep2 (
        .clk_i      (ifclk),
        .rst_i      (reset),
        .push_i     (ep2_push),
        .push_dat_i (out_data),
        .commit_i   (ep2_push),
        .pop_i      (ep2_pop),
        .head_o     (ep2_head),
        .empty_o    (ep2_empty),
        .full_o     (ep2_full),
        .count_o    (ep2_count)
    );

    // Packet framing has no meaning on EP2
    assign ep2_last_unused = ep2_head.last;
    assign fx2_fd_out      = ep2_empty ? 16'h0000 : ep2_head.dat;

    // ---------------- EP6: master -> host ----------------
    assign ep6_wr_req = !fx2_slwr_b && ep6_sel;
    assign ep6_push   = ep6_wr_req && !ep6_full;
    assign ep6_pktend = !fx2_pktend_b && ep6_sel;

    // pend_nxt includes this cycle's write so SLWR+PKTEND closes the packet on that word
    assign pend_nxt   = pend_cnt_q + {CNT_ZERO[DEPTH_LOG2:1], ep6_push};
    assign ep6_auto   = AUTO_EN && (pend_nxt == PKT_CNT);
    assign ep6_commit = (ep6_pktend && (pend_nxt != CNT_ZERO)) || ep6_auto;
    assign pend_cnt_d = ep6_commit ? CNT_ZERO : pend_nxt;
    assign zlp_d      = ep6_pktend && (pend_nxt == CNT_ZERO);

    assign ep6_pop = in_valid && in_ready;

    fx2_emu_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_ep6 (
        .clk_i      (ifclk),
        .rst_i      (reset),
        .push_i     (ep6_push),
        .push_dat_i (fx2_fd_in),
        .commit_i   (ep6_commit),
        .pop_i      (ep6_pop),
        .head_o     (ep6_head),
        .empty_o    (ep6_empty),
        .full_o     (ep6_full),
        .count_o    (ep6_count)
    );

    assign in_valid = !ep6_empty;
    assign in_data  = in_valid ? ep6_head.dat : 16'h0000;
    assign in_last  = in_valid && ep6_head.last;
    assign in_zlp   = zlp_q;

    // ---------------- flags and errors ----------------
    assign ep6_free = FIFO_WORDS - ep6_count;

    // Built from the already-updated counts, so flags trail the causing edge by one cycle
    always_comb begin
        flags_d               = '0;
        flags_d[FLAG_EP2_NE]  = (ep2_count != CNT_ZERO);
        flags_d[FLAG_EP6_NF]  = !ep6_full;
        flags_d[FLAG_EP6_NAF] = (ep6_free > AFULL_CNT);
    end

    assign err_udf_d = err_udf_q || (ep2_rd_req && ep2_empty);
    assign err_ovf_d = err_ovf_q || (ep6_wr_req && ep6_full);

    assign fx2_flags     = flags_q;
    assign err_underflow = err_udf_q;
    assign err_overflow  = err_ovf_q;

    always_ff @(posedge ifclk or posedge reset) begin
        if (reset) begin
            pend_cnt_q <= '0;
            flags_q    <= FLAGS_RST;
            zlp_q      <= 1'b0;
            err_udf_q  <= 1'b0;
            err_ovf_q  <= 1'b0;
        end else begin
            pend_cnt_q <= pend_cnt_d;
            flags_q    <= flags_d;
            zlp_q      <= zlp_d;
            err_udf_q  <= err_udf_d;
            err_ovf_q  <= err_ovf_d;
        end
    end

endmodule

// File: tb/tb_fx2_slave_fifo_emu.sv
// Purpose: self-checking bench for fx2_slave_fifo_emu; EP6 words are predicted into a
//          scoreboard queue as the master writes/commits and compared as the host drains.
// Latency: n/a. Backpressure: host in_ready driven per scenario.
module tb_fx2_slave_fifo_emu;
    import fx2_emu_pkg::*;

    localparam int DEPTH = 512;
    localparam int PKT   = 256;
`ifdef FX2_EMU_AUTOCOMMIT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic        ifclk = 1'b0;
    logic        reset;
    logic        fx2_sloe_b, fx2_slrd_b, fx2_slwr_b, fx2_pktend_b;
    logic [1:0]  fx2_fifo_addr;
    logic [15:0] fx2_fd_in, fx2_fd_out;
    logic        fx2_fd_oe;
    logic [2:0]  fx2_flags;
    logic [15:0] out_data;
    logic        out_valid, out_ready;
    logic [15:0] in_data;
    logic        in_valid, in_last, in_ready, in_zlp;
    logic        err_underflow, err_overflow;

    fx2_slave_fifo_emu dut (
        .ifclk         (ifclk),
        .reset         (reset),
        .fx2_sloe_b    (fx2_sloe_b),
        .fx2_slrd_b    (fx2_slrd_b),
        .fx2_slwr_b    (fx2_slwr_b),
        .fx2_pktend_b  (fx2_pktend_b),
        .fx2_fifo_addr (fx2_fifo_addr),
        .fx2_fd_in     (fx2_fd_in),
        .fx2_fd_out    (fx2_fd_out),
        .fx2_fd_oe     (fx2_fd_oe),
        .fx2_flags     (fx2_flags),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_last       (in_last),
        .in_ready      (in_ready),
        .in_zlp        (in_zlp),
        .err_underflow (err_underflow),
        .err_overflow  (err_overflow)
    );

    always #5 ifclk = ~ifclk;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [16:0] exp_q[$];   // committed words the host should see: {last, data}
    logic [15:0] pend_q[$];  // words written but not yet committed
    int          ep6_occ = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge ifclk);
        #1;
    endtask

    task automatic commit_model();
        for (int i = 0; i < pend_q.size(); i++)
            exp_q.push_back({logic'(i == pend_q.size() - 1), pend_q[i]});
        pend_q.delete();
    endtask

    task automatic ep6_write(input logic [15:0] d, input logic pe);
        fx2_fifo_addr = EP6_ADDR;
        fx2_fd_in     = d;
        fx2_slwr_b    = 1'b0;
        fx2_pktend_b  = !pe;
        cyc();
        fx2_slwr_b   = 1'b1;
        fx2_pktend_b = 1'b1;
        if (ep6_occ < DEPTH) begin
            pend_q.push_back(d);
            ep6_occ++;
        end
        if (AUTO && pend_q.size() == PKT) commit_model();
        if (pe) commit_model();
    endtask

    task automatic ep6_pktend();
        logic zlp_exp;
        zlp_exp       = (pend_q.size() == 0);
        fx2_fifo_addr = EP6_ADDR;
        fx2_pktend_b  = 1'b0;
        cyc();
        fx2_pktend_b = 1'b1;
        chk("in_zlp_on_pktend", in_zlp, zlp_exp);
        commit_model();
    endtask

    task automatic host_push(input logic [15:0] d);
        out_data  = d;
        out_valid = 1'b1;
        cyc();
        out_valid = 1'b0;
    endtask

    task automatic drain();
        in_ready = 1'b1;
        for (int t = 0; t < 2000 && exp_q.size() != 0; t++) cyc();
        chk("drain_remaining", exp_q.size(), 0);
        chk("in_valid_after_drain", in_valid, 1'b0);
        in_ready = 1'b0;
    endtask

    // Host-side scoreboard: every accepted EP6 word must match the next prediction
    always @(negedge ifclk) begin
        if (!reset && in_valid && in_ready) begin
            if (exp_q.size() == 0) begin
                chk("in_unexpected_word", in_valid, 1'b0);
            end else begin
                chk("in_word", {15'b0, in_last, in_data}, {15'b0, exp_q.pop_front()});
                ep6_occ--;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        fx2_sloe_b = 1'b1; fx2_slrd_b = 1'b1; fx2_slwr_b = 1'b1; fx2_pktend_b = 1'b1;
        fx2_fifo_addr = EP2_ADDR; fx2_fd_in = '0;
        out_data = '0; out_valid = 1'b0; in_ready = 1'b0;
        repeat (3) cyc();
        reset = 1'b0;
        cyc();

        // Reset state
        chk("rst_flags", fx2_flags, 3'b110);
        chk("rst_fd_oe", fx2_fd_oe, 1'b0);
        chk("rst_fd_out", fx2_fd_out, 16'h0);
        chk("rst_out_ready", out_ready, 1'b1);
        chk("rst_in_valid", in_valid, 1'b0);
        chk("rst_in_last", in_last, 1'b0);
        chk("rst_in_zlp", in_zlp, 1'b0);
        chk("rst_err_udf", err_underflow, 1'b0);
        chk("rst_err_ovf", err_overflow, 1'b0);

        // EP2: host fills 1..4, master reads them back FWFT
        for (int i = 1; i <= 4; i++) host_push(16'(i));
        cyc();
        chk("ep2_ne_after_fill", fx2_flags[FLAG_EP2_NE], 1'b1);
        fx2_sloe_b    = 1'b0;
        fx2_fifo_addr = EP2_ADDR;
        #1 chk("fd_oe_ep2", fx2_fd_oe, 1'b1);
        fx2_slrd_b = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge ifclk);
            chk("fd_out_seq", fx2_fd_out, 16'(i));
            cyc();
        end
        fx2_slrd_b = 1'b1;
        chk("ep2_ne_latency", fx2_flags[FLAG_EP2_NE], 1'b1);
        chk("fd_out_empty", fx2_fd_out, 16'h0);
        cyc();
        chk("ep2_ne_fall", fx2_flags[FLAG_EP2_NE], 1'b0);
        chk("no_underflow", err_underflow, 1'b0);
        fx2_fifo_addr = EP6_ADDR;
        #1 chk("fd_oe_ep6", fx2_fd_oe, 1'b0);
        fx2_sloe_b = 1'b1;
        // One strobe past empty
        fx2_fifo_addr = EP2_ADDR;
        fx2_slrd_b    = 1'b0;
        cyc();
        fx2_slrd_b = 1'b1;
        chk("underflow_set", err_underflow, 1'b1);
        cyc();
        chk("underflow_sticky", err_underflow, 1'b1);

        // EP6: three words then PKTEND alone
        for (int i = 0; i < 3; i++) ep6_write(16'hA000 + 16'(i), 1'b0);
        @(negedge ifclk);
        chk("ep6_hidden_before_commit", in_valid, 1'b0);
        ep6_pktend();
        @(negedge ifclk);
        chk("ep6_visible_after_commit", in_valid, 1'b1);
        drain();

        // Zero-length packet
        ep6_pktend();
        cyc();
        chk("in_zlp_one_cycle", in_zlp, 1'b0);
        chk("zlp_no_words", in_valid, 1'b0);

        // SLWR and PKTEND together after two writes
        ep6_write(16'h0011, 1'b0);
        ep6_write(16'h0022, 1'b0);
        ep6_write(16'hBEEF, 1'b1);
        @(negedge ifclk);
        chk("simul_commit_visible", in_valid, 1'b1);
        drain();

        // One full packet of PKT words
        for (int i = 0; i < PKT; i++) begin
            if (i == PKT - 1) begin
                @(negedge ifclk);
                chk("pkt_hidden_before_last", in_valid, 1'b0);
            end
            ep6_write(16'h1000 + 16'(i), 1'b0);
        end
        @(negedge ifclk);
        chk("pkt_autocommit", in_valid, AUTO);
        if (!AUTO) ep6_pktend();
        drain();
        ep6_pktend();

        // Fill EP6 to capacity and one beyond with the host stalled
        for (int k = 1; k <= DEPTH + 1; k++) begin
            ep6_write(16'h2000 + 16'(k), 1'b0);
            if (k == 508) chk("naf_still_high", fx2_flags[FLAG_EP6_NAF], 1'b1);
            if (k == 509) chk("naf_fall", fx2_flags[FLAG_EP6_NAF], 1'b0);
            if (k == 512) begin
                chk("nf_still_high", fx2_flags[FLAG_EP6_NF], 1'b1);
                chk("no_overflow_yet", err_overflow, 1'b0);
            end
            if (k == 513) begin
                chk("nf_fall", fx2_flags[FLAG_EP6_NF], 1'b0);
                chk("overflow_set", err_overflow, 1'b1);
            end
        end
        ep6_pktend();
        drain();

        // Reset with a packet in flight on EP6 and words waiting in EP2
        for (int i = 0; i < 5; i++) ep6_write(16'h3000 + 16'(i), 1'b0);
        for (int i = 0; i < 3; i++) host_push(16'h4000 + 16'(i));
        #2 reset = 1'b1;
        #1;
        chk("midrst_flags", fx2_flags, 3'b110);
        chk("midrst_fd_oe", fx2_fd_oe, 1'b0);
        chk("midrst_fd_out", fx2_fd_out, 16'h0);
        chk("midrst_out_ready", out_ready, 1'b1);
        chk("midrst_in_valid", in_valid, 1'b0);
        chk("midrst_in_last", in_last, 1'b0);
        chk("midrst_in_zlp", in_zlp, 1'b0);
        chk("midrst_err_udf", err_underflow, 1'b0);
        chk("midrst_err_ovf", err_overflow, 1'b0);
        pend_q.delete();
        ep6_occ = 0;
        cyc();
        reset = 1'b0;
        in_ready = 1'b1;
        repeat (2) cyc();
        chk("postrst_in_valid", in_valid, 1'b0);
        chk("postrst_flags", fx2_flags, 3'b110);
        chk("postrst_queue", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fx2_slave_fifo_emu.md
Name: fx2_slave_fifo_emu

Overview:
- Synthesizable FX2 slave-FIFO responder: the FX2 side of the slave-FIFO bus that our fpga top drives as master.
- Sits opposite the fpga slave-FIFO master, either in an FPGA-to-FPGA bridge or as the RTL stand-in for the FX2 model in regressions.
- Implements two endpoints: EP2 (OUT, host->FPGA, read by master via SLRD) and EP6 (IN, FPGA->host, written by master via SLWR/PKTEND).
- Host side uses valid/ready streams.

Parameters:
- DEPTH_LOG2, 9, log2 of words per endpoint FIFO (512 x 16-bit).
- PKT_WORDS, 256, words per full EP6 packet (512 bytes); must be <= 2**DEPTH_LOG2.
- AFULL_MARGIN, 4, EP6 almost-full asserts when free words <= AFULL_MARGIN.

Ports:
- ifclk  in  1  interface clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- fx2_sloe_b  in  1  output enable from master, active low.
- fx2_slrd_b  in  1  read strobe, active low.
- fx2_slwr_b  in  1  write strobe, active low.
- fx2_pktend_b  in  1  packet end, active low.
- fx2_fifo_addr  in  2  endpoint select: 2'b00=EP2, 2'b10=EP6.
- fx2_fd_in  in  16  data from master.
- fx2_fd_out  out  16  data to master.
- fx2_fd_oe  out  1  drive enable for the top-level FD tristate.
- fx2_flags  out  3  [0]=EP2 not-empty, [1]=EP6 not-full, [2]=EP6 not-almost-full.
- out_data  in  16  host word into EP2.
- out_valid  in  1  host word valid.
- out_ready  out  1  EP2 can accept.
- in_data  out  16  committed EP6 word.
- in_valid  out  1  committed EP6 word available.
- in_last  out  1  in_data is last word of its packet.
- in_ready  in  1  host accepts the EP6 word.
- in_zlp  out  1  one-cycle pulse: zero-length packet committed.
- err_underflow  out  1  sticky: SLRD on empty EP2.
- err_overflow  out  1  sticky: SLWR on full EP6.

Behaviour:
- Reset:
  - All FIFOs are emptied. Uncommitted EP6 data is discarded.
  - fx2_flags=3'b110 (EP2 empty, EP6 not full, not almost full).
  - fx2_fd_oe=0, fx2_fd_out=0, out_ready=1, in_valid=0, in_last=0, in_zlp=0, both err_*=0.
- FD drive:
  - fx2_fd_oe = !fx2_sloe_b && fx2_fifo_addr==EP2. This is combinational from the inputs.
  - fx2_fd_out = EP2 head word in first-word-fall-through mode, registered storage; 0 when EP2 is empty.
- EP2 read:
  - fx2_slrd_b==0 && addr==EP2 at a clock edge pops the head when non-empty.
  - On empty: no pop, err_underflow set.
  - SLRD with any other address is ignored.
- EP2 fill:
  - out_valid && out_ready pushes out_data.
  - out_ready = !full.
  - A push and a pop in the same cycle are both honoured, count unchanged.
- EP6 write:
  - fx2_slwr_b==0 && addr==EP6 pushes fx2_fd_in at the write pointer when not full.
  - Write when full: word dropped, err_overflow set.
  - pend_cnt counts words written since the last commit.
- EP6 commit:
  - The commit pointer advances to the write pointer, tagging the last written word with last=1, when either:
    - fx2_pktend_b==0 && addr==EP6, or
    - pend_cnt reaches PKT_WORDS (auto-commit).
  - SLWR and PKTEND in the same cycle: the word is written first, then included as the packet's last word.
  - PKTEND with pend_cnt==0 and no same-cycle write: no storage change, in_zlp pulses for one cycle.
  - Commit resets pend_cnt to 0.
- Host drain:
  - in_valid = rd_ptr != commit_ptr. in_last is the stored last bit.
  - Words are popped on in_valid && in_ready.
- Flags:
  - Registered from post-update counts; one ifclk of latency after the causing edge.
  - The master must tolerate one extra strobe after a flag deasserts. Those strobes are handled by the underflow/overflow rules above.
- Pointers: DEPTH_LOG2+1 bits with a wrap bit. Full when addresses are equal and wrap bits differ.

Optional Feature:
- Macro: FX2_EMU_AUTOCOMMIT_EN.
- Defined: auto-commit at PKT_WORDS as described above.
- Undefined: only PKTEND commits.
  - pend_cnt is still kept for debug.
  - Once uncommitted data fills EP6, fx2_flags[1]=0 and further writes are overflows until PKTEND.

Decomposition:
- Package fx2_emu_pkg:
  - endpoint address constants EP2_ADDR=2'b00, EP6_ADDR=2'b10;
  - flag bit indices FLAG_EP2_NE=0, FLAG_EP6_NF=1, FLAG_EP6_NAF=2.
- Sub-module fx2_emu_fifo: sync FWFT FIFO of 17-bit entries (data + last) with a separate commit pointer and commit input.
  - EP2 instance ties commit to push.
  - EP6 instance uses the commit logic above.

Test Plan:
- Host pushes 0x0001..0x0004 into EP2; master holds sloe_b=0, addr=00, slrd_b=0 for 4 cycles -> fx2_fd_out sequence 1,2,3,4; flags[0] falls one cycle after the 4th pop; err_underflow stays 0.
- Master writes 0xA000..0xA002 to EP6, then pktend_b=0 alone -> in_valid stays 0 until the commit; host then sees 3 words, in_last=1 only on 0xA002.
- Auto-commit build: 256 consecutive EP6 writes -> in_valid rises after the 256th, word 256 has in_last=1; pktend with no pending data -> in_zlp pulse, no new words.
- Simultaneous slwr_b=0 and pktend_b=0 with data 0xBEEF after 2 prior writes -> 3-word packet ending in 0xBEEF with in_last=1.
- Fill EP6 to 512 words with in_ready=0 -> flags[2] falls at 508 written, flags[1] falls at 512; 513th write sets err_overflow, FIFO contents unchanged.
- Assert reset mid-packet (5 uncommitted EP6 words, 3 EP2 words) -> all outputs at reset values next cycle; after release no in_valid, flags=3'b110.
